// File: rtl/priority_merge_arbiter.sv
// Fixed-priority merge of INPUT_COUNT ready/valid streams into one.
// Ports:
//   clock, clear_n      : clock, synchronous active-low reset
//   input_valid/ready   : per-input handshake (bit i = input i)
//   input_data          : packed words, input i at [WORD_WIDTH*i +: WORD_WIDTH]
//   requests_mask       : per-input grant eligibility
//   output_valid/ready  : merged handshake
//   output_data         : merged word (zero when nothing granted)
//   grant               : current one-hot or zero grant
//   grant_previous      : grant registered on the last rising edge
module priority_merge_arbiter #(
    parameter int    WORD_WIDTH     = 8,
    parameter int    INPUT_COUNT    = 4,
    parameter string IMPLEMENTATION = "AND",
    localparam int   TOTAL_WIDTH    = WORD_WIDTH * INPUT_COUNT
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic [INPUT_COUNT-1:0] input_valid,
    output logic [INPUT_COUNT-1:0] input_ready,
    input  logic [TOTAL_WIDTH-1:0] input_data,
    input  logic [INPUT_COUNT-1:0] requests_mask,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [WORD_WIDTH-1:0]  output_data,
    output logic [INPUT_COUNT-1:0] grant,
    output logic [INPUT_COUNT-1:0] grant_previous
);

    logic [INPUT_COUNT-1:0] req;
    logic [INPUT_COUNT-1:0] prio;
    logic [INPUT_COUNT-1:0] grant_d;
    logic [INPUT_COUNT-1:0] grant_prev_q;
    logic                   hold;

    assign req  = input_valid & requests_mask;
    // Isolate the lowest-index set bit: highest priority wins.
    assign prio = req & (~req + INPUT_COUNT'(1));
    // The holder keeps its turn as long as it still requests.
    assign hold = |(grant_prev_q & req);

    always_comb begin
        grant_d = '0;
        if (clear_n) begin
            grant_d = hold ? grant_prev_q : prio;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            grant_prev_q <= '0;
        end else begin
            grant_prev_q <= grant_d;
        end
    end

    assign grant          = grant_d;
    assign grant_previous = grant_prev_q;
    assign output_valid   = |grant_d;

    generate
        if (IMPLEMENTATION == "AND") begin : g_and
            always_comb begin
                output_data = '0;
                for (int i = 0; i < INPUT_COUNT; i++) begin
                    output_data = output_data
                        | ({WORD_WIDTH{grant_d[i]}}
                           & input_data[WORD_WIDTH*i +: WORD_WIDTH]);
                end
            end
            assign input_ready = {INPUT_COUNT{output_ready}} & grant_d;
        end else if (IMPLEMENTATION == "MUX") begin : g_mux
            always_comb begin
                output_data = '0;
                for (int i = 0; i < INPUT_COUNT; i++) begin
                    output_data = output_data
                        | (grant_d[i]
                           ? input_data[WORD_WIDTH*i +: WORD_WIDTH]
                           : WORD_WIDTH'(0));
                end
            end
            always_comb begin
                input_ready = '0;
                for (int i = 0; i < INPUT_COUNT; i++) begin
                    input_ready[i] = grant_d[i] ? output_ready : 1'b0;
                end
            end
        end else begin : g_bad
            $error("priority_merge_arbiter: IMPLEMENTATION must be AND or MUX");
        end
    endgenerate

endmodule

// File: tb/tb_priority_merge_arbiter.sv
// Scoreboard bench for priority_merge_arbiter with directed vectors.
// Stimulus queues expected responses; a negedge monitor pops and compares.
module tb_priority_merge_arbiter;

    typedef struct packed {
        logic [3:0] grant;
        logic       ovalid;
        logic [3:0] iready;
        logic [7:0] odata;
        logic [3:0] gprev;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear_n;
    logic [3:0]  input_valid;
    logic [3:0]  input_ready;
    logic [31:0] input_data;
    logic [3:0]  requests_mask;
    logic        output_valid;
    logic        output_ready;
    logic [7:0]  output_data;
    logic [3:0]  grant;
    logic [3:0]  grant_previous;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   stepno = 0;

    priority_merge_arbiter #(
        .WORD_WIDTH(8),
        .INPUT_COUNT(4),
        .IMPLEMENTATION("AND")
    ) dut (
        .clock(clock),
        .clear_n(clear_n),
        .input_valid(input_valid),
        .input_ready(input_ready),
        .input_data(input_data),
        .requests_mask(requests_mask),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .output_data(output_data),
        .grant(grant),
        .grant_previous(grant_previous)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int n,
                       input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", nm, n, act, req);
        end
    endtask

    int mon_n = 0;
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            mon_n++;
            chk("grant", mon_n, {4'b0, grant}, {4'b0, e.grant});
            chk("output_valid", mon_n, {7'b0, output_valid}, {7'b0, e.ovalid});
            chk("input_ready", mon_n, {4'b0, input_ready}, {4'b0, e.iready});
            chk("output_data", mon_n, output_data, e.odata);
            chk("grant_previous", mon_n, {4'b0, grant_previous},
                {4'b0, e.gprev});
        end
    end

    task automatic step(input logic clr, input logic [3:0] v,
                        input logic [3:0] m, input logic r,
                        input logic [3:0] g, input logic ov,
                        input logic [3:0] ir, input logic [7:0] d,
                        input logic [3:0] gp);
        exp_t e;
        @(posedge clock);
        #1;
        clear_n       = clr;
        input_valid   = v;
        requests_mask = m;
        output_ready  = r;
        e.grant  = g;
        e.ovalid = ov;
        e.iready = ir;
        e.odata  = d;
        e.gprev  = gp;
        sb.push_back(e);
        stepno++;
    endtask

    initial begin
        clear_n       = 1'b0;
        input_valid   = 4'b1111;
        requests_mask = 4'b1111;
        output_ready  = 1'b1;
        input_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // reset held two cycles with everything valid
        step(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 4'b0000, 8'h00, 4'b0000);
        step(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 4'b0000, 8'h00, 4'b0000);
        // release: pure priority
        step(1, 4'b1111, 4'b1111, 1, 4'b0001, 1, 4'b0001, 8'hA0, 4'b0000);
        // priority among 2,3
        step(1, 4'b1100, 4'b1111, 1, 4'b0100, 1, 4'b0100, 8'hA2, 4'b0001);
        // hold against preemption by input 0
        step(1, 4'b1101, 4'b1111, 1, 4'b0100, 1, 4'b0100, 8'hA2, 4'b0100);
        // holder drops: same-cycle re-arbitration
        step(1, 4'b0001, 4'b1111, 1, 4'b0001, 1, 4'b0001, 8'hA0, 4'b0100);
        // backpressure, 3 cycles
        step(1, 4'b0010, 4'b1111, 0, 4'b0010, 1, 4'b0000, 8'hA1, 4'b0001);
        step(1, 4'b0010, 4'b1111, 0, 4'b0010, 1, 4'b0000, 8'hA1, 4'b0010);
        step(1, 4'b0010, 4'b1111, 0, 4'b0010, 1, 4'b0000, 8'hA1, 4'b0010);
        step(1, 4'b0010, 4'b1111, 1, 4'b0010, 1, 4'b0010, 8'hA1, 4'b0010);
        // mask off input 0
        step(1, 4'b0011, 4'b1110, 1, 4'b0010, 1, 4'b0010, 8'hA1, 4'b0010);
        step(1, 4'b0001, 4'b1110, 1, 4'b0000, 0, 4'b0000, 8'h00, 4'b0010);
        // idle
        step(1, 4'b0000, 4'b1111, 1, 4'b0000, 0, 4'b0000, 8'h00, 4'b0000);
        step(1, 4'b0000, 4'b1111, 1, 4'b0000, 0, 4'b0000, 8'h00, 4'b0000);
        // mask change on the holder releases immediately
        step(1, 4'b0110, 4'b1111, 1, 4'b0010, 1, 4'b0010, 8'hA1, 4'b0000);
        step(1, 4'b0110, 4'b1101, 1, 4'b0100, 1, 4'b0100, 8'hA2, 4'b0010);
        // reset mid-transfer drops the hold
        step(0, 4'b0110, 4'b1111, 1, 4'b0000, 0, 4'b0000, 8'h00, 4'b0100);
        step(1, 4'b0110, 4'b1111, 1, 4'b0010, 1, 4'b0010, 8'hA1, 4'b0000);
        // all valid while 1 holds
        step(1, 4'b1111, 4'b1111, 0, 4'b0010, 1, 4'b0000, 8'hA1, 4'b0010);
        step(1, 4'b1011, 4'b1111, 1, 4'b0010, 1, 4'b0010, 8'hA1, 4'b0010);
        step(1, 4'b1001, 4'b1111, 1, 4'b0001, 1, 4'b0001, 8'hA0, 4'b0010);

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clock);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
